// File: rtl/w452p_core.sv
// w452p_core: multi-cycle core for the 16-bit w452 instruction set with a configurable datapath,
// ready/ack memory handshakes, a generic coprocessor port, self-branch halt and instret counter.
module w452p_core #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     COP_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            cop_go,
  output logic [1:0]      cop_op,
  output logic [XLEN-1:0] cop_a,
  output logic [XLEN-1:0] cop_b,
  input  logic            cop_done,
  input  logic [XLEN-1:0] cop_result,
  output logic            halted,
  output logic            cop_err,
  output logic [XLEN-1:0] instret
);

  localparam logic [3:0] OpBeq = 4'd0;
  localparam logic [3:0] OpBne = 4'd1;
  localparam logic [3:0] OpBlt = 4'd2;
  localparam logic [3:0] OpBle = 4'd3;
  localparam logic [3:0] OpJr  = 4'd4;
  localparam logic [3:0] OpJrl = 4'd5;
  localparam logic [3:0] OpLd  = 4'd6;
  localparam logic [3:0] OpSt  = 4'd7;
  localparam logic [3:0] OpAdd = 4'd8;
  localparam logic [3:0] OpSub = 4'd9;
  localparam logic [3:0] OpAdi = 4'd10;
  localparam logic [3:0] OpLdp = 4'd11;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StCop, StWb, StHalt
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] res_q;
  logic [3:0]      dest_q;
  logic [31:0]     cop_cnt_q;
  logic [XLEN-1:0] rf_q [16];

  logic [3:0]      op;
  logic [3:0]      rs;
  logic [3:0]      rt;
  logic [3:0]      rd;
  logic [XLEN-1:0] imm8;
  logic [XLEN-1:0] imm4;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] br_sum;
  logic [XLEN-1:0] jr_sum;
  logic [XLEN-1:0] next_pc;
  logic            br_taken;
  logic            self_loop;

  assign op        = ir_q[15:12];
  assign rs        = ir_q[11:8];
  assign rt        = ir_q[7:4];
  assign rd        = ir_q[3:0];
  assign imem_addr = pc_q;

  always_comb begin
    imm8     = {{(XLEN-8){ir_q[7]}}, ir_q[7:0]};
    imm4     = {{(XLEN-4){ir_q[3]}}, ir_q[3:0]};
    npc      = pc_q + XLEN'(2);
    br_sum   = npc + (imm8 << 1);
    jr_sum   = a_q + (imm8 << 1);
    br_taken = 1'b0;
    unique case (op[1:0])
      2'd0: br_taken = (a_q == '0);
      2'd1: br_taken = (a_q != '0);
      2'd2: br_taken = a_q[XLEN-1];
      2'd3: br_taken = a_q[XLEN-1] || (a_q == '0);
    endcase
    next_pc = npc;
    if (op == OpJr || op == OpJrl) begin
      next_pc = {jr_sum[XLEN-1:1], 1'b0};
    end else if (op <= OpBle && br_taken) begin
      next_pc = {br_sum[XLEN-1:1], 1'b0};
    end
    // Only branches and JR halt on a self-target; a not-taken branch never matches pc.
    self_loop = (op <= OpJr) && (next_pc == pc_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= {RESET_PC[XLEN-1:1], 1'b0};
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      dest_q     <= '0;
      cop_cnt_q  <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cop_go     <= 1'b0;
      cop_op     <= '0;
      cop_a      <= '0;
      cop_b      <= '0;
      halted     <= 1'b0;
      cop_err    <= 1'b0;
      instret    <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_req && imem_ack) begin
            ir_q     <= imem_rdata;
            imem_req <= 1'b0;
            state_q  <= StDecode;
          end else begin
            imem_req <= 1'b1;
          end
        end
        StDecode: begin
          // r0 is never written, so it always reads as zero.
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          state_q <= StExec;
        end
        StExec: begin
          pc_q   <= next_pc;
          dest_q <= rd;
          unique case (op)
            OpBeq, OpBne, OpBlt, OpBle, OpJr: begin
              instret <= instret + XLEN'(1);
              if (self_loop) begin
                halted  <= 1'b1;
                state_q <= StHalt;
              end else begin
                state_q <= StFetch;
              end
            end
            OpJrl: begin
              res_q   <= npc;
              dest_q  <= 4'd15;
              state_q <= StWb;
            end
            OpLd: begin
              dmem_addr <= a_q + (imm4 << 2);
              dmem_we   <= 1'b0;
              dest_q    <= rt;
              state_q   <= StMem;
            end
            OpSt: begin
              dmem_addr  <= a_q + (imm4 << 2);
              dmem_we    <= 1'b1;
              dmem_wdata <= b_q;
              state_q    <= StMem;
            end
            OpLdp: begin
              dmem_addr <= npc + (imm8 << 2);
              dmem_we   <= 1'b0;
              dest_q    <= rs;
              state_q   <= StMem;
            end
            OpAdd: begin
              res_q   <= a_q + b_q;
              state_q <= StWb;
            end
            OpSub: begin
              res_q   <= a_q - b_q;
              state_q <= StWb;
            end
            OpAdi: begin
              res_q   <= a_q + imm8;
              dest_q  <= rs;
              state_q <= StWb;
            end
            default: begin
              // FAD/FSB/FML/FDV map onto coprocessor codes add/sub/mult/div.
              cop_op    <= op[1:0] ^ 2'b10;
              cop_a     <= a_q;
              cop_b     <= b_q;
              cop_go    <= 1'b1;
              cop_cnt_q <= '0;
              state_q   <= StCop;
            end
          endcase
        end
        StMem: begin
          if (dmem_req && dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              instret <= instret + XLEN'(1);
              state_q <= StFetch;
            end else begin
              res_q   <= dmem_rdata;
              state_q <= StWb;
            end
          end else begin
            dmem_req <= 1'b1;
          end
        end
        StCop: begin
          cop_go <= 1'b0;
          if (cop_done) begin
            res_q   <= cop_result;
            state_q <= StWb;
          end else if (COP_TIMEOUT != 0 && cop_cnt_q == COP_TIMEOUT - 1) begin
            res_q   <= '1;
            cop_err <= 1'b1;
            state_q <= StWb;
          end else begin
            cop_cnt_q <= cop_cnt_q + 32'd1;
          end
        end
        StWb: begin
          if (dest_q != 4'd0) rf_q[dest_q] <= res_q;
          instret <= instret + XLEN'(1);
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w452p_core.sv
// Directed bench for w452p_core (XLEN=16) with handshaking memory and coprocessor responders.
module tb_w452p_core;
  localparam int unsigned XLEN     = 16;
  localparam logic [15:0] RESET_PC = 16'h0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        cop_go, cop_done;
  logic [1:0]  cop_op;
  logic [15:0] cop_a, cop_b, cop_result;
  logic        halted, cop_err;
  logic [15:0] instret;

  always #5 clk = ~clk;

  w452p_core #(.XLEN(XLEN), .RESET_PC(RESET_PC), .COP_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .cop_go(cop_go), .cop_op(cop_op), .cop_a(cop_a), .cop_b(cop_b),
    .cop_done(cop_done), .cop_result(cop_result),
    .halted(halted), .cop_err(cop_err), .instret(instret)
  );

  // Stimulus configuration (written by the main sequence only).
  logic [15:0] prog [64];
  int          imem_wait, dmem_wait;
  logic        stale_ack;
  int          cop_plan [4];
  logic [15:0] cop_res_plan [4];

  // Logs (each written by its responder only).
  logic [15:0] fetch_log [64];
  int          nfetch;
  logic [15:0] dm_addr_log [16], dm_data_log [16];
  logic        dm_we_log [16];
  int          ndm, dreq_len;
  logic        dreq_stable;
  logic [1:0]  cop_op_log [4];
  logic [15:0] cop_a_log [4], cop_b_log [4];
  int          ngo;

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  initial begin : imem_resp
    int cnt = 0;
    nfetch = 0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (reset) begin
        cnt = 0;
        nfetch = 0;
      end else if (imem_req) begin
        if (cnt >= imem_wait) begin
          imem_ack = 1'b1;
          imem_rdata = prog[nfetch % 64];
          fetch_log[nfetch % 64] = imem_addr;
          nfetch++;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : dmem_resp
    int cnt = 0;
    logic [15:0] a0, d0;
    logic w0;
    ndm = 0;
    dreq_len = 0;
    dreq_stable = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ack = stale_ack;
      if (reset) begin
        cnt = 0;
        ndm = 0;
      end else if (dmem_req) begin
        if (cnt == 0) begin
          a0 = dmem_addr; d0 = dmem_wdata; w0 = dmem_we; dreq_stable = 1'b1;
        end else if (dmem_addr !== a0 || dmem_wdata !== d0 || dmem_we !== w0) begin
          dreq_stable = 1'b0;
        end
        if (cnt >= dmem_wait) begin
          dmem_ack = 1'b1;
          dmem_rdata = dmem_addr ^ 16'h5A5A;
          dm_addr_log[ndm % 16] = dmem_addr;
          dm_data_log[ndm % 16] = dmem_wdata;
          dm_we_log[ndm % 16] = dmem_we;
          ndm++;
          dreq_len = cnt + 1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : cop_resp
    int cnt = 0;
    int cur = 0;
    bit active = 1'b0;
    ngo = 0;
    cop_done = 1'b0;
    cop_result = '0;
    forever begin
      @(negedge clk);
      cop_done = 1'b0;
      if (reset) begin
        active = 1'b0;
        ngo = 0;
      end else begin
        if (cop_go) begin
          cur = ngo % 4;
          cop_op_log[cur] = cop_op;
          cop_a_log[cur] = cop_a;
          cop_b_log[cur] = cop_b;
          ngo++;
          active = 1'b1;
          cnt = 0;
        end
        if (active) begin
          if (cop_plan[cur] >= 0 && cnt == cop_plan[cur]) begin
            cop_done = 1'b1;
            cop_result = cop_res_plan[cur];
            active = 1'b0;
          end else cnt++;
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int p);
    while (cyc < p) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq(tag, halted, 1);
  endtask

  task automatic check_idle(input string tag);
    int reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req) reqs++;
    end
    check_eq(tag, reqs, 0);
  endtask

  task automatic load_prog(input logic [15:0] p [16], input int n);
    for (int i = 0; i < 64; i++) prog[i] = (i < n) ? p[i] : 16'h00FF;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] p [16];
    int n;
    int stale_seen;
    reset = 1'b1;
    imem_wait = 0;
    dmem_wait = 0;
    stale_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin cop_plan[i] = -1; cop_res_plan[i] = '0; end
    for (int i = 0; i < 16; i++) p[i] = 16'h00FF;
    #3;
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, 16'h0020);
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_cop_go", cop_go, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_cop_err", cop_err, 0);
    check_eq("rst_instret", instret, 0);

    // ALU, store, load and LDP with zero-wait memory.
    p[0] = 16'hA105; p[1] = 16'hA2FD; p[2] = 16'h8123; p[3] = 16'h7030;
    p[4] = 16'h6241; p[5] = 16'hB502; p[6] = 16'h7040; p[7] = 16'h7050; p[8] = 16'h00FF;
    load_prog(p, 9);
    apply_reset();
    run_to(14); check_eq("alu_instret_p14", instret, 2);
    run_to(15); check_eq("alu_instret_p15", instret, 3);
    run_to(21); check_eq("st_instret_p21", instret, 4);
    run_to(27); check_eq("ld_instret_p27", instret, 4);
    run_to(28); check_eq("ld_instret_p28", instret, 5);
    wait_halt("t1_halt", 300);
    check_eq("t1_instret", instret, 9);
    check_eq("t1_pc", imem_addr, 16'h0030);
    check_eq("t1_add_result", dm_data_log[0], 16'h0002);
    check_eq("t1_st_addr", dm_addr_log[0], 16'h0000);
    check_eq("t1_ld_addr", dm_addr_log[1], 16'h0001);
    check_eq("t1_ld_we", dm_we_log[1], 0);
    check_eq("t1_ldp_addr", dm_addr_log[2], 16'h0034);
    check_eq("t1_ld_data", dm_data_log[3], 16'h5A5B);
    check_eq("t1_ldp_data", dm_data_log[4], 16'h5A6E);
    check_idle("t1_idle_after_halt");

    // Store with three wait cycles on dmem_ack.
    p[0] = 16'hA105; p[1] = 16'h7012; p[2] = 16'h00FF;
    load_prog(p, 3);
    dmem_wait = 3;
    apply_reset();
    run_to(13);
    check_eq("st_wait_instret_p13", instret, 1);
    check_eq("st_wait_req_held", dmem_req, 1);
    run_to(14);
    check_eq("st_wait_instret_p14", instret, 2);
    check_eq("st_wait_req_fell", dmem_req, 0);
    check_eq("st_wait_addr", dm_addr_log[0], 16'h0008);
    check_eq("st_wait_data", dm_data_log[0], 16'h0005);
    check_eq("st_wait_we", dm_we_log[0], 1);
    check_eq("st_wait_req_len", dreq_len, 4);
    check_eq("st_wait_stable", dreq_stable, 1);
    wait_halt("t2_halt", 200);
    dmem_wait = 0;

    // 16-bit wrap, signed branch taken, branch not taken.
    p[0] = 16'hA17F; p[1] = 16'hA17F; p[2] = 16'hA17F; p[3] = 16'hA17F; p[4] = 16'h7010;
    p[5] = 16'hA301; p[6] = 16'h9034; p[7] = 16'h7040; p[8] = 16'h2402; p[9] = 16'h1005;
    p[10] = 16'h00FF;
    load_prog(p, 11);
    apply_reset();
    wait_halt("t3_halt", 500);
    check_eq("t3_adi_sum", dm_data_log[0], 16'h01FC);
    check_eq("t3_sub_neg1", dm_data_log[1], 16'hFFFF);
    check_eq("t3_blt_target", fetch_log[9], 16'h0036);
    check_eq("t3_bne_fallthru", fetch_log[10], 16'h0038);
    check_eq("t3_instret", instret, 11);

    // JR, JRL to its own pc, then self-branch halt.
    p[0] = 16'h4008; p[1] = 16'h5008; p[2] = 16'h70F0; p[3] = 16'h00FF;
    load_prog(p, 4);
    apply_reset();
    wait_halt("t4_halt", 300);
    check_eq("t4_jr_target", fetch_log[1], 16'h0010);
    check_eq("t4_jrl_target", fetch_log[2], 16'h0010);
    check_eq("t4_r15_link", dm_data_log[0], 16'h0012);
    check_eq("t4_halt_pc", imem_addr, 16'h0012);
    check_eq("t4_instret", instret, 4);
    check_idle("t4_idle_after_halt");

    // Coprocessor: done after 2, done with go, then timeout.
    p[0] = 16'hA105; p[1] = 16'hA203; p[2] = 16'hE124; p[3] = 16'h7040; p[4] = 16'hD125;
    p[5] = 16'h7050; p[6] = 16'hC123; p[7] = 16'h7030; p[8] = 16'h00FF;
    load_prog(p, 9);
    cop_plan[0] = 2;  cop_res_plan[0] = 16'h1234;
    cop_plan[1] = 0;  cop_res_plan[1] = 16'h0042;
    cop_plan[2] = -1; cop_res_plan[2] = 16'hDEAD;
    apply_reset();
    n = 0;
    while (ndm < 2 && n < 300) begin @(negedge clk); n++; end
    check_eq("t5_no_err_before_timeout", cop_err, 0);
    wait_halt("t5_halt", 400);
    check_eq("t5_ngo", ngo, 3);
    check_eq("t5_fml_op", cop_op_log[0], 0);
    check_eq("t5_fsb_op", cop_op_log[1], 3);
    check_eq("t5_fad_op", cop_op_log[2], 2);
    check_eq("t5_cop_a", cop_a_log[0], 16'h0005);
    check_eq("t5_cop_b", cop_b_log[0], 16'h0003);
    check_eq("t5_fml_result", dm_data_log[0], 16'h1234);
    check_eq("t5_fsb_same_cycle", dm_data_log[1], 16'h0042);
    check_eq("t5_timeout_result", dm_data_log[2], 16'hFFFF);
    check_eq("t5_cop_err", cop_err, 1);
    check_eq("t5_instret", instret, 9);

    // Reset asserted while a store is waiting; stale dmem_ack afterwards.
    p[0] = 16'hA105; p[1] = 16'h7012; p[2] = 16'h00FF;
    load_prog(p, 3);
    dmem_wait = 20;
    apply_reset();
    n = 0;
    while (!dmem_req && n < 60) begin @(negedge clk); n++; end
    check_eq("t6_dreq_seen", dmem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_dreq_async_drop", dmem_req, 0);
    check_eq("t6_pc_reset", imem_addr, 16'h0020);
    check_eq("t6_instret_reset", instret, 0);
    stale_ack = 1'b1;
    dmem_wait = 0;
    p[0] = 16'hA107; p[1] = 16'h7010; p[2] = 16'h00FF;
    load_prog(p, 3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    stale_seen = 0;
    repeat (5) begin
      @(posedge clk);
      cyc++;
      #1;
      if (dmem_req) stale_seen++;
    end
    check_eq("t6_stale_no_dreq", stale_seen, 0);
    check_eq("t6_first_fetch", fetch_log[0], 16'h0020);
    check_eq("t6_instret_p5", instret, 1);
    stale_ack = 1'b0;
    wait_halt("t6_halt", 200);
    check_eq("t6_ndm", ndm, 1);
    check_eq("t6_st_data", dm_data_log[0], 16'h0007);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
